apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge.sv | 174 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// APB4 initiator. Takes single-beat read/write commands on a valid/ready
// command port, decodes them to one of two slave windows, runs the
// SETUP/ACCESS handshake (with an optional PREADY timeout) and returns the
// result on a valid/ready response port. One command outstanding at a time.
module apb_master_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] A_START_SLAVE0 = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] A_END_SLAVE0   = 32'h0000_1FFF,
  parameter logic [ADDR_WIDTH-1:0] A_START_SLAVE1 = 32'h0000_2000,
  parameter logic [ADDR_WIDTH-1:0] A_END_SLAVE1   = 32'h0000_2FFF,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_strb,
  input  logic [2:0]            cmd_prot,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB
  output logic [1:0]            PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // Counter wide enough to hold TIMEOUT_CYCLES; at least one bit so the
  // design still elaborates with the timeout disabled.
  localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state_q, state_d;
  logic             sel_q;          // 0 = slave 0, 1 = slave 1
  logic [CNT_W-1:0] wait_cnt_q;

  logic hit0, hit1, hit_any;
  logic accept, xfer_done, xfer_timeout;

  // Address decode; slave 0 window takes priority if the windows overlap.
  always_comb begin
    hit0    = (cmd_addr >= A_START_SLAVE0) && (cmd_addr <= A_END_SLAVE0);
    hit1    = (cmd_addr >= A_START_SLAVE1) && (cmd_addr <= A_END_SLAVE1);
    hit_any = hit0 || hit1;
  end

  // State register.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking (<=) so every register in the
    // design samples pre-edge values, independent of statement order.
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // left one unassigned would infer a latch.
    state_d      = state_q;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    PSEL         = 2'b00;
    PENABLE      = 1'b0;
    accept       = 1'b0;
    xfer_done    = 1'b0;
    xfer_timeout = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = hit_any ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
        PSEL    = sel_q ? 2'b10 : 2'b01;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL    = sel_q ? 2'b10 : 2'b01;
        PENABLE = 1'b1;
        // PREADY in the last allowed cycle still counts as completion.
        if (PREADY) begin
          xfer_done = 1'b1;
          state_d   = ST_RESP;
        end else if (TIMEOUT_EN && (wait_cnt_q == CNT_LAST)) begin
          xfer_timeout = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture, wait counting and response registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      sel_q       <= 1'b0;
      wait_cnt_q  <= '0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= 4'b0000;
      PPROT       <= 3'b000;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        // A decode miss goes straight to the response with an error.
        rsp_rdata   <= '0;
        rsp_err     <= !hit_any;
        rsp_timeout <= 1'b0;
        // Bus-facing registers only move for a real transfer, so the APB
        // signals keep their last value across decode misses.
        if (hit_any) begin
          sel_q      <= !hit0;
          wait_cnt_q <= '0;
          PWRITE     <= cmd_write;
          PADDR      <= cmd_addr;
          PWDATA     <= cmd_wdata;
          // Reads must drive all-zero strobes.
          PSTRB      <= cmd_write ? cmd_strb : 4'b0000;
          PPROT      <= cmd_prot;
        end
      end

      if ((state_q == ST_ACCESS) && !PREADY && !xfer_timeout)
        wait_cnt_q <= wait_cnt_q + 1'b1;

      // PSLVERR is only meaningful in the completing ACCESS cycle.
      if (xfer_done) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_err   <= PSLVERR;
      end

      if (xfer_timeout) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed bench for apb_master_bridge with TIMEOUT_CYCLES = 4. Inputs are
// driven and outputs sampled on the falling edge of PCLK.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [1:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;

  int n_checks = 0;
  int n_errors = 0;

  apb_master_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PPROT       (PPROT),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one command for a single cycle; returns in the cycle after accept.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    check("cmd_ready_before_issue", 64'(cmd_ready), 64'h1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 64'(rsp_valid), 64'h0);
    check("cmd_ready_after_hs", 64'(cmd_ready), 64'h1);
  endtask

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_psel",        64'(PSEL),        64'h0);
    check("rst_penable",     64'(PENABLE),     64'h0);
    check("rst_pwrite",      64'(PWRITE),      64'h0);
    check("rst_paddr",       64'(PADDR),       64'h0);
    check("rst_pwdata",      64'(PWDATA),      64'h0);
    check("rst_pstrb",       64'(PSTRB),       64'h0);
    check("rst_pprot",       64'(PPROT),       64'h0);
    check("rst_rsp_valid",   64'(rsp_valid),   64'h0);
    check("rst_rsp_err",     64'(rsp_err),     64'h0);
    check("rst_rsp_timeout", 64'(rsp_timeout), 64'h0);
    check("rst_rsp_rdata",   64'(rsp_rdata),   64'h0);
    check("rst_cmd_ready",   64'(cmd_ready),   64'h1);
    PRESETn = 1'b1;
    tick();

    // Zero-wait write to slave 0
    PREADY = 1'b1;
    issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0101, 3'b010);
    check("wr_setup_psel",    64'(PSEL),      64'h1);
    check("wr_setup_penable", 64'(PENABLE),   64'h0);
    check("wr_setup_paddr",   64'(PADDR),     64'h1000);
    check("wr_setup_pwrite",  64'(PWRITE),    64'h1);
    check("wr_setup_pwdata",  64'(PWDATA),    64'hDEAD_BEEF);
    check("wr_setup_pstrb",   64'(PSTRB),     64'h5);
    check("wr_setup_pprot",   64'(PPROT),     64'h2);
    check("wr_setup_cmdrdy",  64'(cmd_ready), 64'h0);
    check("wr_setup_rspv",    64'(rsp_valid), 64'h0);
    tick();
    check("wr_access_psel",    64'(PSEL),      64'h1);
    check("wr_access_penable", 64'(PENABLE),   64'h1);
    check("wr_access_pstrb",   64'(PSTRB),     64'h5);
    check("wr_access_rspv",    64'(rsp_valid), 64'h0);
    tick();
    check("wr_resp_valid",   64'(rsp_valid),   64'h1);
    check("wr_resp_err",     64'(rsp_err),     64'h0);
    check("wr_resp_rdata",   64'(rsp_rdata),   64'h0);
    check("wr_resp_timeout", 64'(rsp_timeout), 64'h0);
    check("wr_resp_psel",    64'(PSEL),        64'h0);
    check("wr_resp_penable", 64'(PENABLE),     64'h0);
    handshake();
    check("wr_paddr_hold", 64'(PADDR), 64'h1000);

    // Read from slave 1 with 3 wait states; PREADY arrives in the 4th
    // (last allowed) ACCESS cycle, so it completes normally. PSLVERR is
    // raised only while PREADY is low and must be ignored.
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_2004, 32'hCAFE_F00D, 4'hF, 3'b001);
    check("rd_setup_psel",    64'(PSEL),    64'h2);
    check("rd_setup_penable", 64'(PENABLE), 64'h0);
    check("rd_setup_pstrb",   64'(PSTRB),   64'h0);
    check("rd_setup_pwrite",  64'(PWRITE),  64'h0);
    check("rd_setup_paddr",   64'(PADDR),   64'h2004);
    PSLVERR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_wait_psel",    64'(PSEL),      64'h2);
      check("rd_wait_penable", 64'(PENABLE),   64'h1);
      check("rd_wait_paddr",   64'(PADDR),     64'h2004);
      check("rd_wait_rspv",    64'(rsp_valid), 64'h0);
    end
    PREADY  = 1'b1;
    PRDATA  = 32'h1234_5678;
    PSLVERR = 1'b0;
    tick();
    check("rd_resp_valid",   64'(rsp_valid),   64'h1);
    check("rd_resp_rdata",   64'(rsp_rdata),   64'h1234_5678);
    check("rd_resp_err",     64'(rsp_err),     64'h0);
    check("rd_resp_timeout", 64'(rsp_timeout), 64'h0);
    check("rd_resp_psel",    64'(PSEL),        64'h0);
    handshake();

    // Decode misses: below slave 0 and just past slave 1
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'b000);
    check("miss_rsp_valid", 64'(rsp_valid),   64'h1);
    check("miss_psel",      64'(PSEL),        64'h0);
    check("miss_penable",   64'(PENABLE),     64'h0);
    check("miss_err",       64'(rsp_err),     64'h1);
    check("miss_timeout",   64'(rsp_timeout), 64'h0);
    check("miss_rdata",     64'(rsp_rdata),   64'h0);
    handshake();
    issue(1'b1, 32'h0000_3000, 32'h1111_2222, 4'hF, 3'b000);
    check("miss2_rsp_valid", 64'(rsp_valid), 64'h1);
    check("miss2_psel",      64'(PSEL),      64'h0);
    check("miss2_err",       64'(rsp_err),   64'h1);
    handshake();

    // Timeout: PREADY held low, exactly 4 ACCESS cycles, then RESP
    PREADY = 1'b0;
    PRDATA = 32'hFFFF_FFFF;
    issue(1'b0, 32'h0000_1FFC, 32'h0, 4'h0, 3'b000);
    check("to_setup_psel",    64'(PSEL),    64'h1);
    check("to_setup_penable", 64'(PENABLE), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_access_psel",    64'(PSEL),      64'h1);
      check("to_access_penable", 64'(PENABLE),   64'h1);
      check("to_access_rspv",    64'(rsp_valid), 64'h0);
    end
    tick();
    check("to_resp_psel",    64'(PSEL),        64'h0);
    check("to_resp_penable", 64'(PENABLE),     64'h0);
    check("to_resp_valid",   64'(rsp_valid),   64'h1);
    check("to_resp_err",     64'(rsp_err),     64'h1);
    check("to_resp_timeout", 64'(rsp_timeout), 64'h1);
    check("to_resp_rdata",   64'(rsp_rdata),   64'h0);
    handshake();

    // Slave error on a write, response back-pressured for 5 cycles
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    issue(1'b1, 32'h0000_2FFC, 32'h0BAD_0BAD, 4'hF, 3'b000);
    check("se_setup_psel", 64'(PSEL), 64'h2);
    tick();
    check("se_access_penable", 64'(PENABLE), 64'h1);
    tick();
    PSLVERR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("se_hold_valid",   64'(rsp_valid),   64'h1);
      check("se_hold_err",     64'(rsp_err),     64'h1);
      check("se_hold_timeout", 64'(rsp_timeout), 64'h0);
      check("se_hold_rdata",   64'(rsp_rdata),   64'h0);
      check("se_hold_cmdrdy",  64'(cmd_ready),   64'h0);
      tick();
    end
    handshake();

    // Reset during ACCESS drops the transfer without a response
    PREADY = 1'b0;
    issue(1'b1, 32'h0000_1004, 32'h5555_AAAA, 4'h3, 3'b100);
    tick();
    check("rm_access_penable", 64'(PENABLE), 64'h1);
    PRESETn = 1'b0;
    tick();
    check("rm_psel",    64'(PSEL),      64'h0);
    check("rm_penable", 64'(PENABLE),   64'h0);
    check("rm_rspv",    64'(rsp_valid), 64'h0);
    check("rm_paddr",   64'(PADDR),     64'h0);
    check("rm_pwrite",  64'(PWRITE),    64'h0);
    check("rm_cmdrdy",  64'(cmd_ready), 64'h1);
    PRESETn = 1'b1;
    tick();
    check("rm_after_rspv", 64'(rsp_valid), 64'h0);

    // Next command after reset completes normally
    PREADY = 1'b1;
    PRDATA = 32'hA5A5_0001;
    issue(1'b0, 32'h0000_1010, 32'h0, 4'hF, 3'b000);
    check("pr_setup_psel", 64'(PSEL), 64'h1);
    tick();
    tick();
    check("pr_resp_valid", 64'(rsp_valid), 64'h1);
    check("pr_resp_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
    check("pr_resp_err",   64'(rsp_err),   64'h0);
    handshake();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
